// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between the fetch frontend and decode.
//
// Captures {pc, instr, misaligned} from fetch and hands entries to decode over a
// valid/ready handshake. Absorbs decode stalls and drops all contents on a redirect.
//
// Optional build macro: FETCH_QUEUE_BYPASS_EN
//   When defined, an empty queue forwards the incoming word to the outputs in the same
//   cycle. If decode takes it, the word is never stored.
//
// Ports:
//   clk, nrst            clock (rising edge), asynchronous active-low reset
//   flush                discard all entries; overrides push and pop
//   in_valid/in_ready    fetch-side handshake; in_ready = !full
//   in_pc/in_instr/in_misaligned  fetched word
//   fetch_stall          = !in_ready, stalls the frontend
//   out_valid/out_ready  decode-side handshake
//   out_pc/out_instr/out_misaligned  head entry (NOP when nothing to present)
//   count                occupied entries, 0..DEPTH

module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  input  logic                     in_misaligned,
  output logic                     in_ready,
  output logic                     fetch_stall,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic                     out_misaligned,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [XLEN-1:0] Nop = XLEN'(32'h0000_0013);

  // Storage is deliberately not reset; only pointers and count are.
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [DEPTH-1:0] mis_mem;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic empty;
  logic full;
  logic bypass;
  logic push;
  logic pop;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CntW'(DEPTH));
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = empty & in_valid & ~flush;
`else
    bypass = 1'b0;
`endif
    in_ready    = ~full;
    fetch_stall = full;
    // A bypassed word that decode accepts this cycle is consumed without being stored.
    push = in_valid & ~full & ~flush & ~(bypass & out_ready);
    pop  = ~empty & out_ready & ~flush;
  end

  // Output mux: stored head wins; bypass only applies when empty.
  always_comb begin
    out_valid      = 1'b0;
    out_pc         = '0;
    out_instr      = Nop;
    out_misaligned = 1'b0;
    if (!empty) begin
      out_valid      = 1'b1;
      out_pc         = pc_mem[rd_ptr_q];
      out_instr      = instr_mem[rd_ptr_q];
      out_misaligned = mis_mem[rd_ptr_q];
    end else if (bypass) begin
      out_valid      = 1'b1;
      out_pc         = in_pc;
      out_instr      = in_instr;
      out_misaligned = in_misaligned;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      instr_mem[wr_ptr_q] <= in_instr;
      mis_mem[wr_ptr_q]   <= in_misaligned;
    end
  end

  assign count = count_q;

endmodule
